gx4000_dma_seq: RTL and testbench

GX4000_DMA_SEQ -- requirements
Module: gx4000_dma_seq

---
 rtl/gx4000_dma_seq.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_gx4000_dma_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gx4000_dma_seq.sv
// GX4000 Plus ASIC DMA sound sequencer: on each scanline, walks the enabled channels
// in order, fetches one 16-bit instruction per channel and turns it into PSG writes.
module gx4000_dma_seq #(
    parameter  int CHANNELS = 3,
    parameter  int ADDR_W   = 16,
    parameter  int PRESC_W  = 8,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                line_strobe,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_sel,
    input  logic [15:0]         cfg_data,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [15:0]         mem_data,
    output logic                ay_wr,
    output logic [3:0]          ay_reg,
    output logic [7:0]          ay_data,
    output logic [CHANNELS-1:0] irq,
    output logic [CHANNELS-1:0] active,
    output logic                overrun
);

    typedef enum logic [2:0] {IDLE, SCAN, FETCH, EXEC, NEXT} state_t;
    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [PRESC_W-1:0] presc_t;
    typedef logic [11:0]        cnt_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                pending_q, pending_d;
    logic [15:0]         instr_q, instr_d;
    addr_t               addr_q [CHANNELS];
    addr_t               addr_d [CHANNELS];
    addr_t               loop_addr_q [CHANNELS];
    addr_t               loop_addr_d [CHANNELS];
    presc_t              presc_q [CHANNELS];
    presc_t              presc_d [CHANNELS];
    presc_t              presc_cnt_q [CHANNELS];
    presc_t              presc_cnt_d [CHANNELS];
    cnt_t                pause_q [CHANNELS];
    cnt_t                pause_d [CHANNELS];
    cnt_t                loop_cnt_q [CHANNELS];
    cnt_t                loop_cnt_d [CHANNELS];
    logic [CHANNELS-1:0] en_q, en_d, irq_q, irq_d, irq_set, irq_clr;
    logic                ay_wr_q, ay_wr_d;
    logic [3:0]          ay_reg_q, ay_reg_d;
    logic [7:0]          ay_data_q, ay_data_d;
    logic                overrun_q, overrun_d;
    logic                daddr_v_q, daddr_v_d, dpresc_v_q, dpresc_v_d, den_v_q, den_v_d;
    addr_t               daddr_q, daddr_d;
    presc_t              dpresc_q, dpresc_d;
    logic                den_q, den_d;

    logic                found;
    logic [CH_W-1:0]     sel;
    logic                defer;
    addr_t               cfg_addr;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            pending_q   <= 1'b0;
            instr_q     <= '0;
            addr_q      <= '{default: '0};
            loop_addr_q <= '{default: '0};
            presc_q     <= '{default: '0};
            presc_cnt_q <= '{default: '0};
            pause_q     <= '{default: '0};
            loop_cnt_q  <= '{default: '0};
            en_q        <= '0;
            irq_q       <= '0;
            ay_wr_q     <= 1'b0;
            ay_reg_q    <= '0;
            ay_data_q   <= '0;
            overrun_q   <= 1'b0;
            daddr_v_q   <= 1'b0;
            daddr_q     <= '0;
            dpresc_v_q  <= 1'b0;
            dpresc_q    <= '0;
            den_v_q     <= 1'b0;
            den_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            pending_q   <= pending_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            loop_addr_q <= loop_addr_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            pause_q     <= pause_d;
            loop_cnt_q  <= loop_cnt_d;
            en_q        <= en_d;
            irq_q       <= irq_d;
            ay_wr_q     <= ay_wr_d;
            ay_reg_q    <= ay_reg_d;
            ay_data_q   <= ay_data_d;
            overrun_q   <= overrun_d;
            daddr_v_q   <= daddr_v_d;
            daddr_q     <= daddr_d;
            dpresc_v_q  <= dpresc_v_d;
            dpresc_q    <= dpresc_d;
            den_v_q     <= den_v_d;
            den_q       <= den_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        pending_d   = pending_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        loop_addr_d = loop_addr_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;
        pause_d     = pause_q;
        loop_cnt_d  = loop_cnt_q;
        en_d        = en_q;
        irq_set     = '0;
        irq_clr     = '0;
        ay_wr_d     = 1'b0;
        ay_reg_d    = ay_reg_q;
        ay_data_d   = ay_data_q;
        overrun_d   = 1'b0;
        daddr_v_d   = daddr_v_q;
        daddr_d     = daddr_q;
        dpresc_v_d  = dpresc_v_q;
        dpresc_d    = dpresc_q;
        den_v_d     = den_v_q;
        den_d       = den_q;
        found       = 1'b0;
        sel         = '0;
        defer       = 1'b0;
        cfg_addr    = addr_t'(cfg_data) & ~addr_t'(1);

        if (state_q == IDLE) begin
            // A strobe coinciding with a pending pass becomes the next pending pass.
            pending_d = enable & pending_q & line_strobe;
        end else if (!enable) begin
            pending_d = 1'b0;
        end else if (line_strobe) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (enable && (line_strobe || pending_q)) begin
                    ch_d    = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    if (!found && i >= 32'(ch_q) && en_q[i]) begin
                        found = 1'b1;
                        sel   = CH_W'(i);
                    end
                end
                if (!enable || !found) begin
                    state_d = IDLE;
                end else if (pause_q[sel] != '0) begin
                    if (presc_cnt_q[sel] != '0) begin
                        presc_cnt_d[sel] = presc_cnt_q[sel] - presc_t'(1);
                    end else begin
                        presc_cnt_d[sel] = presc_q[sel];
                        pause_d[sel]     = pause_q[sel] - 12'd1;
                    end
                    if (int'(sel) == CHANNELS - 1) state_d = IDLE;
                    else                           ch_d    = sel + CH_W'(1);
                end else begin
                    ch_d    = sel;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // With the gate closed the word is discarded unretired, so it is refetched later.
                if (mem_ack) begin
                    if (!enable) begin
                        state_d = IDLE;
                    end else begin
                        instr_d      = mem_data;
                        addr_d[ch_q] = addr_q[ch_q] + addr_t'(2);
                        state_d      = EXEC;
                    end
                end
            end
            EXEC: begin
                case (instr_q[15:12])
                    4'h0: begin
                        ay_wr_d   = 1'b1;
                        ay_reg_d  = instr_q[11:8];
                        ay_data_d = instr_q[7:0];
                    end
                    4'h1: begin
                        pause_d[ch_q]     = instr_q[11:0];
                        presc_cnt_d[ch_q] = presc_q[ch_q];
                    end
                    4'h2: begin
                        loop_cnt_d[ch_q]  = instr_q[11:0];
                        loop_addr_d[ch_q] = addr_q[ch_q];
                    end
                    4'h4: begin
                        if (instr_q[0] && loop_cnt_q[ch_q] != '0) begin
                            loop_cnt_d[ch_q] = loop_cnt_q[ch_q] - 12'd1;
                            addr_d[ch_q]     = loop_addr_q[ch_q];
                        end
                        if (instr_q[4]) irq_set[ch_q] = 1'b1;
                        if (instr_q[5]) en_d[ch_q]    = 1'b0;
                    end
                    default: ;
                endcase
                state_d = NEXT;
            end
            NEXT: begin
                if (!enable || int'(ch_q) == CHANNELS - 1) begin
                    state_d = IDLE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = SCAN;
                end
            end
            default: state_d = IDLE;
        endcase

        // Writes held back while the channel was in service land once its instruction retires.
        if (state_q != FETCH && state_q != EXEC) begin
            if (daddr_v_q) begin
                addr_d[ch_q]      = daddr_q;
                pause_d[ch_q]     = '0;
                presc_cnt_d[ch_q] = '0;
                loop_cnt_d[ch_q]  = '0;
            end
            if (dpresc_v_q) presc_d[ch_q] = dpresc_q;
            if (den_v_q)    en_d[ch_q]    = den_q;
            daddr_v_d  = 1'b0;
            dpresc_v_d = 1'b0;
            den_v_d    = 1'b0;
        end

        if (cfg_wr && int'(cfg_ch) < CHANNELS) begin
            defer = (state_q == FETCH || state_q == EXEC) && cfg_ch == ch_q;
            case (cfg_sel)
                2'd0: begin
                    if (defer) begin
                        daddr_v_d = 1'b1;
                        daddr_d   = cfg_addr;
                    end else begin
                        addr_d[cfg_ch]      = cfg_addr;
                        pause_d[cfg_ch]     = '0;
                        presc_cnt_d[cfg_ch] = '0;
                        loop_cnt_d[cfg_ch]  = '0;
                    end
                end
                2'd1: begin
                    if (defer) begin
                        dpresc_v_d = 1'b1;
                        dpresc_d   = presc_t'(cfg_data);
                    end else begin
                        presc_d[cfg_ch] = presc_t'(cfg_data);
                    end
                end
                2'd2: begin
                    irq_clr[cfg_ch] = cfg_data[1];
                    if (defer) begin
                        den_v_d = 1'b1;
                        den_d   = cfg_data[0];
                    end else begin
                        en_d[cfg_ch] = cfg_data[0];
                    end
                end
                default: ;
            endcase
        end

        irq_d = (irq_q & ~irq_clr) | irq_set;
    end

    assign mem_req  = (state_q == FETCH);
    assign mem_addr = addr_q[ch_q];
    assign ay_wr    = ay_wr_q;
    assign ay_reg   = ay_reg_q;
    assign ay_data  = ay_data_q;
    assign irq      = irq_q;
    assign active   = en_q & {CHANNELS{enable}};
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_gx4000_dma_seq.sv
// Directed bench for gx4000_dma_seq: bench plays the instruction memory and checks
// PSG writes, fetch addresses, pauses, loops, irq, overrun and reset behaviour.
module tb_gx4000_dma_seq;

    localparam int CHANNELS = 3;
    localparam int ADDR_W   = 16;
    localparam int PRESC_W  = 8;
    localparam int CH_W     = 2;

    logic                clk_sys = 1'b0;
    logic                reset_n = 1'b0;
    logic                enable = 1'b1;
    logic                line_strobe = 1'b0;
    logic                cfg_wr = 1'b0;
    logic [CH_W-1:0]     cfg_ch = '0;
    logic [1:0]          cfg_sel = '0;
    logic [15:0]         cfg_data = '0;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ack = 1'b0;
    logic [15:0]         mem_data = '0;
    logic                ay_wr;
    logic [3:0]          ay_reg;
    logic [7:0]          ay_data;
    logic [CHANNELS-1:0] irq;
    logic [CHANNELS-1:0] active;
    logic                overrun;

    int checks  = 0;
    int errors  = 0;
    int ay_cnt  = 0;
    int r1_cnt  = 0;
    int ovr_cnt = 0;
    int req_cyc = 0;
    int base;

    logic [15:0] seq_addr [8] = '{16'h0300, 16'h0302, 16'h0304, 16'h0302,
                                  16'h0304, 16'h0302, 16'h0304, 16'h0306};
    logic [15:0] seq_data [8] = '{16'h2002, 16'h0110, 16'h4001, 16'h0110,
                                  16'h4001, 16'h0110, 16'h4001, 16'h4020};

    gx4000_dma_seq #(.CHANNELS(CHANNELS), .ADDR_W(ADDR_W), .PRESC_W(PRESC_W)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .enable      (enable),
        .line_strobe (line_strobe),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .ay_wr       (ay_wr),
        .ay_reg      (ay_reg),
        .ay_data     (ay_data),
        .irq         (irq),
        .active      (active),
        .overrun     (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every step samples 1 time unit after the rising edge and tallies output events.
    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (ay_wr === 1'b1) begin
            ay_cnt++;
            if (ay_reg === 4'd1 && ay_data === 8'h10) r1_cnt++;
        end
        if (overrun === 1'b1) ovr_cnt++;
        if (mem_req === 1'b1) req_cyc++;
    endtask

    task automatic settle();
        repeat (6) tick();
    endtask

    task automatic cfg(input logic [CH_W-1:0] ch, input logic [1:0] s, input logic [15:0] d);
        cfg_wr = 1'b1; cfg_ch = ch; cfg_sel = s; cfg_data = d;
        tick();
        cfg_wr = 1'b0; cfg_data = '0;
    endtask

    task automatic strobe();
        line_strobe = 1'b1;
        tick();
        line_strobe = 1'b0;
    endtask

    task automatic wait_req(input logic [15:0] exp_addr);
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("fetch_req", 32'(mem_req), 32'd1);
        check("fetch_addr", 32'(mem_addr), 32'(exp_addr));
    endtask

    task automatic ack(input logic [15:0] data, input int delay);
        for (int i = 0; i < delay; i++) tick();
        mem_ack = 1'b1; mem_data = data;
        tick();
        mem_ack = 1'b0; mem_data = '0;
        check("req_drop", 32'(mem_req), 32'd0);
    endtask

    task automatic fetch(input logic [15:0] exp_addr, input logic [15:0] data, input int delay);
        wait_req(exp_addr);
        ack(data, delay);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_ay_wr", 32'(ay_wr), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        tick();

        // Single PSG write with a slow acknowledge, then address advance.
        cfg(2'd0, 2'd0, 16'h0100);
        cfg(2'd0, 2'd2, 16'h0001);
        check("active_ch0", 32'(active), 32'b001);
        strobe();
        fetch(16'h0100, 16'h0712, 2);
        check("ay_lat1", 32'(ay_wr), 32'd0);
        tick();
        check("ay_wr", 32'(ay_wr), 32'd1);
        check("ay_reg", 32'(ay_reg), 32'd7);
        check("ay_data", 32'(ay_data), 32'h12);
        tick();
        check("ay_one_cycle", 32'(ay_wr), 32'd0);
        settle();
        strobe();
        fetch(16'h0102, 16'h4000, 0);
        settle();
        check("ay_total", 32'(ay_cnt), 32'd1);

        // Pause 3 with prescaler 2 skips nine lines.
        cfg(2'd0, 2'd2, 16'h0000);
        cfg(2'd1, 2'd1, 16'h0002);
        cfg(2'd1, 2'd0, 16'h0200);
        cfg(2'd1, 2'd2, 16'h0001);
        check("active_ch1", 32'(active), 32'b010);
        strobe();
        fetch(16'h0200, 16'h1003, 0);
        settle();
        req_cyc = 0;
        repeat (9) begin
            strobe();
            settle();
        end
        check("pause_no_fetch", 32'(req_cyc), 32'd0);
        strobe();
        fetch(16'h0202, 16'h4000, 0);
        settle();

        // Loop program on ch2: three writes to reg 1, then STOP.
        cfg(2'd1, 2'd2, 16'h0000);
        cfg(2'd2, 2'd0, 16'h0300);
        cfg(2'd2, 2'd2, 16'h0001);
        base = ay_cnt;
        r1_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            strobe();
            fetch(seq_addr[i], seq_data[i], 0);
            settle();
        end
        check("loop_reg1_writes", 32'(r1_cnt), 32'd3);
        check("loop_all_writes", 32'(ay_cnt - base), 32'd3);
        check("stop_active", 32'(active), 32'b000);
        req_cyc = 0;
        strobe();
        settle();
        check("stopped_no_fetch", 32'(req_cyc), 32'd0);

        // INT set against a simultaneous irq clear, then a later clear.
        cfg(2'd0, 2'd0, 16'h0400);
        cfg(2'd0, 2'd2, 16'h0001);
        strobe();
        fetch(16'h0400, 16'h4010, 0);
        cfg(2'd0, 2'd2, 16'h0003);
        check("irq_set_wins", 32'(irq), 32'b001);
        settle();
        check("active_after_defer", 32'(active), 32'b001);
        cfg(2'd0, 2'd2, 16'h0003);
        check("irq_clear", 32'(irq), 32'b000);

        // Address write during the fetch lands after the instruction retires.
        strobe();
        wait_req(16'h0402);
        cfg(2'd0, 2'd0, 16'h0501);
        check("addr_stable_in_fetch", 32'(mem_addr), 32'h0402);
        ack(16'h4000, 0);
        settle();
        strobe();
        fetch(16'h0500, 16'h4000, 0);
        settle();

        // Strobes while the fetch is stalled: one pending pass, one overrun.
        base = ovr_cnt;
        strobe();
        wait_req(16'h0502);
        strobe();
        strobe();
        tick();
        check("overrun_pulses", 32'(ovr_cnt - base), 32'd1);
        ack(16'h4000, 0);
        wait_req(16'h0504);
        ack(16'h4010, 0);
        settle();
        req_cyc = 0;
        settle();
        check("pending_single", 32'(req_cyc), 32'd0);
        check("overrun_total", 32'(ovr_cnt - base), 32'd1);
        check("irq_before_rst", 32'(irq), 32'b001);

        // Gate closed: no activity.
        enable = 1'b0;
        tick();
        check("gate_active", 32'(active), 32'b000);
        req_cyc = 0;
        strobe();
        settle();
        check("gate_no_fetch", 32'(req_cyc), 32'd0);
        enable = 1'b1;

        // Reset in the middle of a handshake.
        strobe();
        wait_req(16'h0506);
        reset_n = 1'b0;
        tick();
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        check("midrst_active", 32'(active), 32'd0);
        reset_n = 1'b1;
        tick();

        // Address wrap at the top of memory.
        cfg(2'd0, 2'd0, 16'hFFFE);
        cfg(2'd0, 2'd2, 16'h0001);
        strobe();
        fetch(16'hFFFE, 16'h4000, 0);
        settle();
        strobe();
        fetch(16'h0000, 16'h4000, 0);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
